pokey_pot_sequencer: RTL and testbench

Sequences POKEY's eight-channel potentiometer (paddle) analog-to-digital scan. A POTGO write starts a scan: the block clears the POT0–POT7 results, presets ALLPOT, and dumps the pot capacitors for one line period. It then counts scan lines and latches the line count for each channel when that channel's comparator input goes high. It sits between the POKEY register decode (POTGO strobe, SKCTL fast-scan bit, POTn/ALLPOT reads) and the external pot pins and dump transistors.

---
 rtl/pokey_pot_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pokey_pot_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pokey_pot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pokey_pot_sequencer
// Purpose  : Sequences the eight-channel potentiometer (paddle) scan. A POTGO
//            strobe clears the POT0-POT7 results, presets ALLPOT and holds the
//            pot capacitors discharged for one line period. The block then
//            counts scan lines and latches the line count for each channel
//            when its (synchronized) comparator input goes high. Channels
//            still open when the count ends latch NUM_LINES.
// Ports    : o2        - system clock, rising edge
//            rst       - synchronous active-high reset
//            potgo_wr  - one-cycle strobe, start/restart a scan
//            fast_scan - 1 = one line tick per o2 cycle
//            pot_in    - asynchronous comparator inputs (1 = crossed)
//            pot_sel   - selects POTn driven on pot_data
//            pot_data  - POT[pot_sel], combinational read mux
//            allpot    - bit i = 1 while channel i is still counting
//            dump      - 1 = dump transistors on
//            scan_busy - 1 while dumping or scanning
// Revision : 1.0 - initial release
// ============================================================================
module pokey_pot_sequencer #(
    parameter int NUM_LINES = 228,
    parameter int LINE_DIV  = 114
) (
    input  logic       o2,
    input  logic       rst,
    input  logic       potgo_wr,
    input  logic       fast_scan,
    input  logic [7:0] pot_in,
    input  logic [2:0] pot_sel,
    output logic [7:0] pot_data,
    output logic [7:0] allpot,
    output logic       dump,
    output logic       scan_busy
);

    localparam logic [7:0] c_last_line = 8'(NUM_LINES - 1);
    localparam logic [7:0] c_num_lines = 8'(NUM_LINES);
    localparam logic [7:0] c_div_last  = 8'(LINE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DUMP = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_presc;
    logic [7:0] r_line;
    logic [7:0] r_pot [8];
    logic [7:0] r_allpot;
    logic [7:0] r_sync1;
    logic [7:0] r_psync;

    state_t     w_state_nxt;
    logic [7:0] w_presc_nxt;
    logic [7:0] w_line_nxt;
    logic [7:0] w_pot_nxt [8];
    logic [7:0] w_allpot_nxt;
    logic       w_tick;

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge o2) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_presc  <= 8'd0;
            r_line   <= 8'd0;
            r_allpot <= 8'd0;
            r_sync1  <= 8'd0;
            r_psync  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_pot[i] <= 8'd0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_presc  <= w_presc_nxt;
            r_line   <= w_line_nxt;
            r_allpot <= w_allpot_nxt;
            // Two-flop synchronizer for the asynchronous comparator inputs.
            r_sync1  <= pot_in;
            r_psync  <= r_sync1;
            for (int i = 0; i < 8; i++) begin
                r_pot[i] <= w_pot_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-data logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_presc_nxt  = r_presc;
        w_line_nxt   = r_line;
        w_allpot_nxt = r_allpot;
        w_tick       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_pot_nxt[i] = r_pot[i];
        end

        case (r_state)
            ST_IDLE: begin
                w_presc_nxt = 8'd0;
            end

            ST_DUMP: begin
                // Dump lasts a full line period in slow mode, one cycle in fast.
                if (fast_scan || (r_presc == c_div_last)) begin
                    w_state_nxt = ST_SCAN;
                    w_presc_nxt = 8'd0;
                    w_line_nxt  = 8'd0;
                end else begin
                    w_presc_nxt = r_presc + 8'd1;
                end
            end

            ST_SCAN: begin
                w_tick = fast_scan || (r_presc == c_div_last);
                // Fast mode always ticks, so the prescaler is held at 0 there.
                w_presc_nxt = w_tick ? 8'd0 : (r_presc + 8'd1);
                if (w_tick) begin
                    for (int i = 0; i < 8; i++) begin
                        if (r_allpot[i] && r_psync[i]) begin
                            w_pot_nxt[i]    = r_line;
                            w_allpot_nxt[i] = 1'b0;
                        end
                    end
                    if (r_line == c_last_line) begin
                        // Close out every channel that never crossed.
                        for (int i = 0; i < 8; i++) begin
                            if (w_allpot_nxt[i]) begin
                                w_pot_nxt[i]    = c_num_lines;
                                w_allpot_nxt[i] = 1'b0;
                            end
                        end
                        w_state_nxt = ST_IDLE;
                        w_line_nxt  = 8'd0;
                    end else begin
                        w_line_nxt = r_line + 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A POTGO write overrides everything above, including a final tick.
        if (potgo_wr) begin
            w_state_nxt  = ST_DUMP;
            w_presc_nxt  = 8'd0;
            w_line_nxt   = 8'd0;
            w_allpot_nxt = 8'hFF;
            for (int i = 0; i < 8; i++) begin
                w_pot_nxt[i] = 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pot_data  = r_pot[pot_sel];
    assign allpot    = r_allpot;
    assign dump      = (r_state != ST_SCAN);
    assign scan_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pokey_pot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pokey_pot_sequencer
// Purpose  : Self-checking bench for pokey_pot_sequencer. Expected results are
//            derived from each channel's input rise time and the scan's tick
//            schedule; allpot, dump and scan_busy are checked every cycle and
//            all POTn results at the start and end of every scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pokey_pot_sequencer;

    localparam int NL    = 228;
    localparam int LD    = 114;
    localparam int NEVER = 1000000;

    logic       o2;
    logic       rst;
    logic       potgo_wr;
    logic       fast_scan;
    logic [7:0] pot_in;
    logic [2:0] pot_sel;
    logic [7:0] pot_data;
    logic [7:0] allpot;
    logic       dump;
    logic       scan_busy;

    int errors = 0;
    int checks = 0;
    int zeros [8] = '{default: 0};

    pokey_pot_sequencer #(
        .NUM_LINES (NL),
        .LINE_DIV  (LD)
    ) dut (
        .o2        (o2),
        .rst       (rst),
        .potgo_wr  (potgo_wr),
        .fast_scan (fast_scan),
        .pot_in    (pot_in),
        .pot_sel   (pot_sel),
        .pot_data  (pot_data),
        .allpot    (allpot),
        .dump      (dump),
        .scan_busy (scan_busy)
    );

    initial o2 = 1'b0;
    always #10 o2 = ~o2;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge offset (from the POTGO edge) at which line count k is taken.
    function automatic int tick_t(input bit fast, input int k);
        return fast ? (k + 2) : (LD * (k + 2));
    endfunction

    // rise = r: pot_in goes high at the negedge after POTGO edge + r
    // (r = -1: already high when POTGO is sampled). Two sync stages mean it
    // can latch at the first tick at least 2 edges after it is sampled.
    function automatic int expect_pot(input bit fast, input int rise);
        for (int k = 0; k < NL; k++) begin
            if (tick_t(fast, k) >= rise + 3) return k;
        end
        return NL;
    endfunction

    task automatic check_pots(input string tag, input int exp [8]);
        for (int i = 0; i < 8; i++) begin
            pot_sel = 3'(i);
            #1;
            chk($sformatf("%s_pot%0d", tag, i), pot_data, 8'(exp[i]));
        end
    endtask

    // Called at a negedge. Issues POTGO, then follows the scan cycle by cycle
    // until it ends, or returns early at the negedge after edge offset stop_t.
    task automatic run_scan(input bit fast, input int rise [8], input int stop_t);
        int         expv [8];
        int         fall [8];
        int         end_t;
        int         start_t;
        logic [7:0] ea;
        logic [7:0] pin;
        end_t   = tick_t(fast, NL - 1);
        start_t = fast ? 1 : LD;
        pin     = 8'd0;
        for (int i = 0; i < 8; i++) begin
            expv[i] = expect_pot(fast, rise[i]);
            fall[i] = (expv[i] < NL) ? tick_t(fast, expv[i]) : end_t;
            if (rise[i] < 0) pin[i] = 1'b1;
        end
        potgo_wr  = 1'b1;
        fast_scan = fast;
        pot_in    = pin;
        for (int t = 0; t <= end_t; t++) begin
            @(posedge o2);
            @(negedge o2);
            potgo_wr = 1'b0;
            for (int i = 0; i < 8; i++) ea[i] = (t < fall[i]);
            chk("allpot", allpot, ea);
            chk("dump", {7'd0, dump}, ((t < start_t) || (t >= end_t)) ? 8'd1 : 8'd0);
            chk("scan_busy", {7'd0, scan_busy}, (t < end_t) ? 8'd1 : 8'd0);
            if (t == 0) check_pots("cleared", zeros);
            if (t == stop_t) return;
            if (t == end_t) begin
                check_pots("result", expv);
                return;
            end
            for (int i = 0; i < 8; i++) if (rise[i] == t) pin[i] = 1'b1;
            pot_in = pin;
        end
    endtask

    function automatic int rnd_rise(input int maxv);
        return int'($urandom_range(0, maxv + 1)) - 1;
    endfunction

    initial begin
        int r [8];

        rst       = 1'b1;
        potgo_wr  = 1'b0;
        fast_scan = 1'b0;
        pot_in    = 8'd0;
        pot_sel   = 3'd0;
        repeat (3) @(negedge o2);
        chk("rst_allpot", allpot, 8'h00);
        chk("rst_dump", {7'd0, dump}, 8'd1);
        chk("rst_busy", {7'd0, scan_busy}, 8'd0);
        check_pots("rst", zeros);
        rst = 1'b0;
        @(negedge o2);

        // Fast scan: channel 0 high throughout, channel 5 for the c=40 tick.
        r = '{-1, NEVER, NEVER, NEVER, NEVER, 39, NEVER, NEVER};
        run_scan(1'b1, r, -1);

        // Fast scan with no crossings.
        r = '{default: NEVER};
        run_scan(1'b1, r, -1);

        // Randomized fast scans.
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) r[i] = rnd_rise(240);
            run_scan(1'b1, r, -1);
        end

        // Restart at the c=100 tick with POT1 already latched at 30.
        r = '{default: NEVER};
        r[1] = 29;
        r[4] = 60;
        run_scan(1'b1, r, 101);
        for (int i = 0; i < 8; i++) r[i] = rnd_rise(240);
        run_scan(1'b1, r, -1);

        // POTGO on the same edge as the final tick.
        r = '{default: NEVER};
        r[2] = 10;
        run_scan(1'b1, r, tick_t(1'b1, NL - 1) - 1);
        for (int i = 0; i < 8; i++) r[i] = rnd_rise(240);
        run_scan(1'b1, r, -1);

        // Reset around c=50 of a fast scan with results already latched.
        r = '{default: NEVER};
        r[0] = -1;
        r[3] = 5;
        r[6] = 20;
        run_scan(1'b1, r, 51);
        rst = 1'b1;
        @(negedge o2);
        chk("rst1_allpot", allpot, 8'h00);
        chk("rst1_dump", {7'd0, dump}, 8'd1);
        @(negedge o2);
        rst = 1'b0;
        chk("rst2_allpot", allpot, 8'h00);
        chk("rst2_dump", {7'd0, dump}, 8'd1);
        chk("rst2_busy", {7'd0, scan_busy}, 8'd0);
        check_pots("rst2", zeros);
        @(negedge o2);
        chk("postrst_dump", {7'd0, dump}, 8'd1);
        chk("postrst_allpot", allpot, 8'h00);

        // Slow scan: channel 2 rises 2 cycles before the c=10 tick edge.
        for (int i = 0; i < 8; i++) r[i] = rnd_rise(LD * 232);
        r[2] = LD + 11 * LD - 3;
        run_scan(1'b0, r, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
